// File: rtl/cpu_bus_pkg.sv
// Shared bus definitions for the CPU core: T-state encoding, default bus
// widths and the values the external bus returns to on reset.
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4
  } tstate_e;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  localparam logic [ADDR_W_DEF-1:0] BUS_ADDR_RST = '0;
  localparam logic [DATA_W_DEF-1:0] BUS_DATA_RST = '0;

endpackage

// File: rtl/mcycle_wait_timer.sv
// T3 wait-state counter; only built when MCYCLE_WAIT_STATE_EN is defined.
// expired flags the T3 cycle whose increment brings the count to WAIT_MAX.
`ifdef MCYCLE_WAIT_STATE_EN
module mcycle_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(WAIT_MAX - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (count_en) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = count_en && (count_q == LIMIT);

endmodule
`endif

// File: rtl/mcycle_bus_ctrl.sv
// Four-T-state machine-cycle sequencer and external memory bus controller.
// MCYCLE_WAIT_STATE_EN enables mem_ready wait states and the T3 timeout.
module mcycle_bus_ctrl
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_write,
  input  logic              is_fetch,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] rdata_out,
  output logic              m1t1,
  output logic              writeback,
  output logic              done,
  output logic              busy,
  output logic              bus_err
);

  tstate_e           state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              write_q, write_d;
  logic              fetch_q, fetch_d;
  logic              timeout_q, timeout_d;

  logic t3_exit;
  logic capture;
  logic expired;
  logic accept;

`ifdef MCYCLE_WAIT_STATE_EN
  mcycle_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q == T2),
    .count_en ((state_q == T3) && !mem_ready),
    .expired  (expired)
  );

  assign t3_exit = mem_ready | expired;
  assign capture = mem_ready;
`else
  // Without wait states T3 is a single cycle and mem_ready has no effect.
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign expired = 1'b0;
  assign t3_exit = 1'b1;
  assign capture = 1'b1;
`endif

  assign accept = start && ((state_q == IDLE) || (state_q == T4));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    write_d   = write_q;
    fetch_d   = fetch_q;
    timeout_d = timeout_q;

    case (state_q)
      IDLE:    if (start) state_d = T1;
      T1:      state_d = T2;
      T2:      state_d = T3;
      T3:      if (t3_exit) state_d = T4;
      T4:      state_d = start ? T1 : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      addr_d  = addr_in;
      wdata_d = wdata_in;
      write_d = is_write;
      fetch_d = is_fetch & ~is_write;
    end

    // A timed-out read leaves rdata untouched because capture is only set by mem_ready.
    if ((state_q == T3) && t3_exit) begin
      timeout_d = expired;
      if (capture && !write_q) begin
        rdata_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= ADDR_W'(BUS_ADDR_RST);
      wdata_q   <= DATA_W'(BUS_DATA_RST);
      rdata_q   <= DATA_W'(BUS_DATA_RST);
      write_q   <= 1'b0;
      fetch_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      write_q   <= write_d;
      fetch_q   <= fetch_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata_out = rdata_q;
  assign busy      = (state_q == T1) || (state_q == T2) || (state_q == T3);
  assign m1t1      = (state_q == T1) && fetch_q;
  assign mem_rd    = ((state_q == T2) || (state_q == T3)) && !write_q;
  assign mem_wr    = ((state_q == T2) || (state_q == T3)) && write_q;
  assign done      = (state_q == T4);
  assign writeback = (state_q == T4) && !write_q && !timeout_q;
  assign bus_err   = (state_q == T4) && timeout_q;

endmodule

// File: doc/mcycle_bus_ctrl.md
Name: mcycle_bus_ctrl

Overview:
- Machine-cycle sequencer and external memory-bus controller for the CPU core.
- Runs each bus access as a 4-T-state machine cycle: T1 address, T2 strobe, T3 sample/wait, T4 writeback.
- Directly upstream of the register file: produces its `m1t1` and `writeback` strobes and the read byte it writes.
- Directly downstream of the register file: consumes its 16-bit address bus and the memory write byte.

Parameters:
- ADDR_W, 16, address bus width.
- DATA_W, 8, data bus width.
- WAIT_MAX, 15, maximum T3 wait-state cycles before timeout; must be ≥1 and ≤255.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request a machine cycle; sampled when accept is possible.
- is_write  in  1  1 = memory write, 0 = memory read; sampled with start.
- is_fetch  in  1  opcode-fetch (M1) cycle; sampled with start; ignored if is_write.
- addr_in  in  ADDR_W  access address from register file.
- wdata_in  in  DATA_W  write byte from register file.
- mem_ready  in  1  external memory ready, sampled in T3.
- mem_rdata  in  DATA_W  external read data.
- mem_addr  out  ADDR_W  registered external address.
- mem_wdata  out  DATA_W  registered external write data.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe.
- rdata_out  out  DATA_W  last captured read byte, to register file data_in.
- m1t1  out  1  one-cycle pulse in T1 of a fetch cycle.
- writeback  out  1  one-cycle pulse in T4 of a successful read or fetch.
- done  out  1  one-cycle pulse in T4 of every cycle.
- busy  out  1  high in T1..T3.
- bus_err  out  1  one-cycle pulse in T4 of a timed-out cycle.

Behaviour:
- States:
  - IDLE: start → T1, else stay.
  - T1: → T2.
  - T2: → T3.
  - T3: → T4 on mem_ready or timeout.
  - T4: start → T1, else → IDLE.
- start is accepted only in IDLE or T4, allowing back-to-back cycles with no bubble.
- start while busy=1 is ignored; no queueing.
- On accept, capture:
  - addr_in → mem_addr
  - wdata_in → mem_wdata
  - is_write
  - is_fetch & ~is_write
- mem_addr and mem_wdata are held until the next accept.
- m1t1 = 1 during T1 of a fetch cycle.
- mem_rd = 1 in T2 and T3 of a read or fetch cycle.
- mem_wr = 1 in T2 and T3 of a write cycle.
- Strobes drop at T4 entry.
- Read capture in T3: when mem_ready=1, mem_rdata → rdata_out at the T3→T4 edge.
- rdata_out holds until the next successful read.
- Writes never change rdata_out.
- Wait counter:
  - Cleared on T2→T3.
  - Increments each T3 cycle with mem_ready=0.
  - When it equals WAIT_MAX with mem_ready still 0 → T4 with timeout flag set.
- Timeout cycle:
  - bus_err pulses in T4.
  - writeback is suppressed.
  - rdata_out is not updated.
- Outputs in T4:
  - writeback = 1 only for a non-timed-out read or fetch.
  - done = 1 always.
- Latency: start accepted at edge N → T1 at N+1, T3 at N+3, T4/done at N+4 (zero waits). Each wait state adds 1.
- Reset (async, any state including mid-cycle):
  - State → IDLE.
  - mem_addr, mem_wdata, rdata_out, wait counter → 0.
  - All strobes and pulses → 0 immediately.
  - No writeback is emitted for the aborted cycle.
- All outputs are registered or decoded purely from the state register; no combinational path from inputs to outputs.

Optional Feature:
- Macro: MCYCLE_WAIT_STATE_EN.
- Defined: mem_ready, the wait counter and timeout are active as described above.
- Undefined:
  - mem_ready is ignored; T3 always lasts exactly one cycle and mem_rdata is captured unconditionally.
  - bus_err is tied to 0.
  - The wait counter is not instantiated.

Decomposition:
- Shared package `cpu_bus_pkg`:
  - T-state encoding constants: IDLE=3'd0, T1=3'd1, T2=3'd2, T3=3'd3, T4=3'd4.
  - ADDR_W/DATA_W defaults.
  - Bus reset constants (address 0, data 0).
- One sub-module, `mcycle_wait_timer`:
  - Parameterised by WAIT_MAX.
  - Ports: clk, rst, clear, count_en, expired.
  - Compiled only under MCYCLE_WAIT_STATE_EN.

Test Plan:
- Fetch, zero wait: start=1, is_fetch=1, addr_in=16'h0100, mem_rdata=8'h3E, mem_ready=1 → m1t1 at N+1; mem_rd at N+2..N+3; rdata_out=8'h3E and writeback at N+4; done at N+4.
- Write: start=1, is_write=1, addr_in=16'hC000, wdata_in=8'h5A → mem_wr at N+2..N+3 with mem_addr=C000 and mem_wdata=5A; no writeback; rdata_out unchanged; done at N+4.
- Wait states (macro on): read with mem_ready low 3 cycles → T3 lasts 4 cycles; done at N+7; rdata_out captured on the ready edge.
- Timeout (macro on, WAIT_MAX=15): mem_ready held 0 → bus_err and done at N+18; no writeback; rdata_out retains its prior value.
- Back-to-back and ignored start:
  - start held high across two cycles → second T1 immediately after first T4.
  - start pulsed in T2 → ignored; FSM returns to IDLE after T4.
- Reset mid-cycle: assert rst during T3 of a read → mem_rd, busy and all outputs 0 within the same cycle; state IDLE; no writeback or done pulse after release.
